// File: rtl/system_nios2_qsys_0_div_pkg.sv
// Shared types, sizing constants and helpers for the Nios II multi-cycle divider.
package system_nios2_qsys_0_div_pkg;

  localparam int DIV_WIDTH_DFLT = 32;
  localparam int CNT_W          = $clog2(DIV_WIDTH_DFLT);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } div_state_t;

  // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
  function automatic logic [DIV_WIDTH_DFLT-1:0] div_mag(
    input logic [DIV_WIDTH_DFLT-1:0] x,
    input logic                      neg
  );
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/system_nios2_qsys_0_div_step.sv
// One combinational radix-2 restoring step: shift {rem, dvd} left and trial-subtract.
module system_nios2_qsys_0_div_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] rem_dvd,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] rem_dvd_next,
  output logic           q_bit
);

  logic [W-1:0] rem;
  logic [W-1:0] dvd;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;

  assign rem    = rem_dvd[2*W-1:W];
  assign dvd    = rem_dvd[W-1:0];
  assign rem_sh = {rem, dvd[W-1]};
  // rem < divisor, so the W+1-bit difference cannot wrap and its MSB is the sign.
  assign diff   = rem_sh - {1'b0, divisor};
  assign q_bit  = ~diff[W];

  // Quotient bit is left to the caller; the vacated dividend LSB is zero here.
  assign rem_dvd_next = {(q_bit ? diff[W-1:0] : rem_sh[W-1:0]), dvd[W-2:0], 1'b0};

endmodule

// File: rtl/system_nios2_qsys_0_div_cell.sv
// Multi-cycle restoring divider with start/busy/done handshake, signed and unsigned modes.
module system_nios2_qsys_0_div_cell
  import system_nios2_qsys_0_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DFLT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  input  logic                 A_div_signed,
  input  logic                 A_div_start,
  output logic                 A_div_busy,
  output logic                 A_div_done,
  output logic [DIV_WIDTH-1:0] A_div_quotient,
  output logic [DIV_WIDTH-1:0] A_div_remainder
);

  localparam int SC_W = $clog2(DIV_WIDTH);

  div_state_t state_reg, state_next;

  logic [DIV_WIDTH-1:0]   rem_reg, dvd_reg, dsr_reg, src1_reg;
  logic [DIV_WIDTH-1:0]   quot_reg, remo_reg;
  logic [SC_W-1:0]        step_cnt_reg;
  logic                   neg_q_reg, neg_r_reg, dz_reg, done_reg;
  logic                   sign1, sign2;
  logic [DIV_WIDTH-1:0]   mag1, mag2;
  logic [2*DIV_WIDTH-1:0] rd_next;
  logic                   q_bit;
  logic [DIV_WIDTH-1:0]   quot_fix, rem_fix;

  assign sign1 = A_div_signed & A_div_src1[DIV_WIDTH-1];
  assign sign2 = A_div_signed & A_div_src2[DIV_WIDTH-1];

  generate
    if (DIV_WIDTH == DIV_WIDTH_DFLT) begin : g_pkg_mag
      assign mag1 = div_mag(A_div_src1, sign1);
      assign mag2 = div_mag(A_div_src2, sign2);
    end else begin : g_gen_mag
      assign mag1 = sign1 ? ('0 - A_div_src1) : A_div_src1;
      assign mag2 = sign2 ? ('0 - A_div_src2) : A_div_src2;
    end
  endgenerate

  system_nios2_qsys_0_div_step #(
    .W(DIV_WIDTH)
  ) u_step (
    .rem_dvd      ({rem_reg, dvd_reg}),
    .divisor      (dsr_reg),
    .rem_dvd_next (rd_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (A_div_start) state_next = ITER;
      ITER:    if (step_cnt_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide-by-zero overrides any sign correction and returns the raw dividend.
  always_comb begin
    quot_fix = neg_q_reg ? ('0 - dvd_reg) : dvd_reg;
    rem_fix  = neg_r_reg ? ('0 - rem_reg) : rem_reg;
    if (dz_reg) begin
      quot_fix = '1;
      rem_fix  = src1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dsr_reg      <= '0;
      src1_reg     <= '0;
      quot_reg     <= '0;
      remo_reg     <= '0;
      step_cnt_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (A_div_start) begin
            rem_reg      <= '0;
            dvd_reg      <= mag1;
            dsr_reg      <= mag2;
            src1_reg     <= A_div_src1;
            neg_q_reg    <= sign1 ^ sign2;
            neg_r_reg    <= sign1;
            dz_reg       <= (A_div_src2 == '0);
            step_cnt_reg <= SC_W'(DIV_WIDTH - 1);
          end
        end
        ITER: begin
          rem_reg <= rd_next[2*DIV_WIDTH-1:DIV_WIDTH];
          dvd_reg <= rd_next[DIV_WIDTH-1:0] | {{(DIV_WIDTH-1){1'b0}}, q_bit};
          if (step_cnt_reg != '0) step_cnt_reg <= step_cnt_reg - SC_W'(1);
        end
        FIX: begin
          quot_reg <= quot_fix;
          remo_reg <= rem_fix;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign A_div_busy      = (state_reg != IDLE);
  assign A_div_done      = done_reg;
  assign A_div_quotient  = quot_reg;
  assign A_div_remainder = remo_reg;

endmodule

// File: tb/tb_system_nios2_qsys_0_div_cell.sv
// Scoreboard bench for the multi-cycle divider: directed vectors, decoupled monitor.
module tb_system_nios2_qsys_0_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        sgn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [31:0] quot, rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  system_nios2_qsys_0_div_cell #(.DIV_WIDTH(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_signed    (sgn),
    .A_div_start     (start),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quot),
    .A_div_remainder (rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got q=%h r=%h expected no done", quot, rem);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_q"}, quot, e.q);
          chk({e.name, "_r"}, rem, e.r);
          chk({e.name, "_lat"}, 32'(cyc - e.start_cyc + 1), 32'd34);
          chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
      end
      if (done && done_prev) begin
        checks++;
        errors++;
        $display("FAIL done_width: got done high 2 cycles expected 1");
      end
    end
    done_prev = done;
  end

  // Caller is positioned at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input string name);
    exp_t e;
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.start_cyc = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; sgn = 1'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quot, 32'd0);
    chk("rst_r", rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Unsigned 100 / 7 with busy tracked over cycles 1..33
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
    for (int k = 1; k <= 33; k++) begin
      chk($sformatf("u100_7_busy_c%0d", k), {31'd0, busy}, 32'd1);
      if (k < 33) begin
        chk($sformatf("u100_7_nodone_c%0d", k), {31'd0, done}, 32'd0);
        @(negedge clk);
      end
    end
    wait_idle("u100_7");

    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");      wait_idle("s_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "s_7_m2");             wait_idle("s_7_m2");
    issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, "u5_0");                       wait_idle("u5_0");
    issue(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, "s5_0");                       wait_idle("s5_0");
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s_m5_0");     wait_idle("s_m5_0");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "s_ovf");      wait_idle("s_ovf");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "u_ovf");      wait_idle("u_ovf");
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "s_m100_7");   wait_idle("s_m100_7");
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, "u_max_1");            wait_idle("u_max_1");

    // Start during an operation is ignored
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, "busy_start");
    repeat (9) @(negedge clk);
    src1 = 32'd9; src2 = 32'd3; sgn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (40) @(negedge clk);

    // Start coincident with done is accepted
    issue(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, "b2b_a");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("b2b_done_seen", {31'd0, seen}, 32'd1);
    end
    issue(32'hFFFF_FFF7, 32'd4, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "b2b_b");
    wait_idle("b2b_b");

    // Reset mid-operation discards it
    issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "rst_mid");
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_q", quot, 32'd0);
    chk("rst_mid_r", rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd77, 32'd7, 1'b0, 32'd11, 32'd0, "post_rst");
    wait_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/system_nios2_qsys_0_div_cell.md
# system_nios2_qsys_0_div_cell

Multi-cycle 32-bit integer divider for the Nios II execute path. It is the inverse of the pipelined multiplier cell: a dividend and divisor go in, and a quotient and remainder come out. It uses a radix-2 restoring algorithm with a start/busy/done handshake, and supports signed and unsigned operation. It sits beside the multiply cell in the processor's A-stage and stalls the pipeline through `A_div_busy`.

## Interface
- `DIV_WIDTH`, default 32: operand and result width. Latency scales as `DIV_WIDTH`+2.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset_n` input, 1 bit: reset, synchronous and active-low.
- `A_div_src1` input, `DIV_WIDTH` bits: dividend, sampled on an accepted start.
- `A_div_src2` input, `DIV_WIDTH` bits: divisor, sampled on an accepted start.
- `A_div_signed` input, 1 bit: 1 selects two's-complement operation, 0 selects unsigned. Sampled on an accepted start.
- `A_div_start` input, 1 bit: request. It is accepted only when the block is in IDLE.
- `A_div_busy` output, 1 bit: high while an operation is in flight.
- `A_div_done` output, 1 bit: one-cycle pulse indicating the result outputs are valid.
- `A_div_quotient` output, `DIV_WIDTH` bits: registered quotient. Holds its value until the next done pulse.
- `A_div_remainder` output, `DIV_WIDTH` bits: registered remainder. Holds its value until the next done pulse.

## Operation
**States**
- IDLE:
  - `A_div_start`=1 loads the magnitude of the dividend into the working register and clears the partial remainder.
  - It latches the magnitude of the divisor, `neg_q` = signed & (sign1 ^ sign2), `neg_r` = signed & sign1, and a divide-by-zero flag (`src2`==0).
  - It loads `step_cnt` with `DIV_WIDTH`-1 and moves to ITER.
- ITER, one step per cycle:
  - Shift {rem, dvd} left by 1 and trial-subtract the divisor (`DIV_WIDTH`+1-bit subtract).
  - If the result is non-negative, keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - When `step_cnt`==0, go to FIX. Otherwise decrement `step_cnt`.
- FIX:
  - Negate the quotient if `neg_q` and the remainder if `neg_r`.
  - Apply overrides, then register the outputs and pulse done. Go to IDLE.

**Arithmetic rules**
- Magnitude: signed negative operand → 0 - x, taken as unsigned. The magnitude of 0x8000_0000 is 0x8000_0000.
- Divide by zero, any signedness: quotient = all ones and remainder = original dividend. No sign correction is applied.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000 and remainder = 0. This falls out of the algorithm and must not be special-cased differently.
- Signed results truncate toward zero. The remainder takes the sign of the dividend.

**Handshake and boundaries**
- `A_div_start` while busy is ignored. It is neither queued nor does it disturb operands.
- `A_div_start` in the same cycle `A_div_done` is high is accepted, because the block is in IDLE then.
- Inputs need to be valid only in the start cycle.
- Reset mid-operation: the next edge puts the block in IDLE, clears busy, done and both result registers, and discards the operation.

## Timing
- Reset values: `A_div_busy`=0, `A_div_done`=0, `A_div_quotient`=0, `A_div_remainder`=0, state=IDLE, `step_cnt`=0.
- Start sampled at edge 0:
  - `A_div_busy` is high in cycles 1..33: 32 ITER cycles plus 1 FIX cycle.
  - `A_div_done` and the results are visible in cycle 34, when busy=0.
- Start-to-done latency is `DIV_WIDTH`+2 = 34 cycles. Back-to-back throughput is one result per 34 cycles.
- `A_div_done` is high for exactly one cycle per accepted start.

## Structure
- Package `system_nios2_qsys_0_div_pkg` holds:
  - The state enum (IDLE, ITER, FIX).
  - The `DIV_WIDTH` default and `CNT_W` = $clog2(`DIV_WIDTH`).
  - A function for two's-complement magnitude.
- Sub-module `system_nios2_qsys_0_div_step` is the combinational restoring step.
  - Inputs: {rem, dvd} and divisor.
  - Outputs: next {rem, dvd} and the quotient bit.
  - It is instantiated once and reused every ITER cycle.

## Test plan
- Unsigned 100 / 7 → q=14, r=2. Busy is high in cycles 1..33 and done pulses exactly in cycle 34.
- Signed -7 / 2 (0xFFFF_FFF9, 0x2) → q=0xFFFF_FFFD, r=0xFFFF_FFFF. Signed 7 / -2 → q=0xFFFF_FFFD, r=1.
- Divide by zero, 5 / 0 in both signed and unsigned mode → q=0xFFFF_FFFF, r=5.
- 0x8000_0000 / 0xFFFF_FFFF:
  - Signed → q=0x8000_0000, r=0.
  - Unsigned → q=0, r=0x8000_0000.
- Start pulsed with new operands at cycle 10 of an operation → ignored, and the first result is unchanged. A new start coincident with done is accepted, and its done arrives 34 cycles later.
- `reset_n`=0 at cycle 10 of an operation → the next cycle has busy=0, done=0 and q=r=0. No done pulse follows. A subsequent start completes normally.
